// File: rtl/switch_debouncer.sv
// switch_debouncer: 16 slide switches, two-flop synchronized, sampled on a
// shared prescaler tick, each bit accepted after STABLE_COUNT matching samples.
module switch_debouncer #(
   parameter int SAMPLE_DIV   = 100000,
   parameter int STABLE_COUNT = 4
) (
   input  logic        SYSCLK,
   input  logic        RST,
   input  logic [15:0] Switches,
   output logic [15:0] DebouncedSwitches,
   output logic [15:0] SwitchEdge,
   output logic        SampleTick
);
   localparam int PW = $clog2(SAMPLE_DIV);
   localparam int CW = $clog2(STABLE_COUNT);
   localparam logic [PW-1:0] DivMax = PW'(SAMPLE_DIV - 1);
   localparam logic [CW-1:0] CntMax = CW'(STABLE_COUNT - 1);

   logic [PW-1:0] prescaler;
   logic [15:0]   sync1;
   logic [15:0]   sync2;
   logic [CW-1:0] stableCnt [16];

   assign SampleTick = (prescaler == DivMax);

   always_ff @(posedge SYSCLK or negedge RST) begin
      if (!RST) begin
         prescaler <= '0;
         sync1     <= '0;
         sync2     <= '0;
      end else begin
         sync1     <= Switches;
         sync2     <= sync1;
         prescaler <= SampleTick ? '0 : prescaler + PW'(1);
      end
   end

   // A nonzero counter means the bit is pending; a matching sample drops it.
   always_ff @(posedge SYSCLK or negedge RST) begin
      if (!RST) begin
         DebouncedSwitches <= '0;
         SwitchEdge        <= '0;
         for (int i = 0; i < 16; i++) begin
            stableCnt[i] <= '0;
         end
      end else begin
         SwitchEdge <= '0;
         if (SampleTick) begin
            for (int i = 0; i < 16; i++) begin
               if (sync2[i] == DebouncedSwitches[i]) begin
                  stableCnt[i] <= '0;
               end else if (stableCnt[i] == CntMax) begin
                  DebouncedSwitches[i] <= sync2[i];
                  SwitchEdge[i]        <= 1'b1;
                  stableCnt[i]         <= '0;
               end else begin
                  stableCnt[i] <= stableCnt[i] + CW'(1);
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_switch_debouncer.sv
// tb_switch_debouncer: scoreboard bench, SAMPLE_DIV=4, STABLE_COUNT=3.
// Cycle 1 is the cycle in which reset is released.
module tb_switch_debouncer;
   localparam int SD = 4;
   localparam int SC = 3;

   typedef struct {
      int          cyc;
      logic [15:0] deb;
      logic [15:0] edg;
   } exp_t;

   logic        SYSCLK;
   logic        RST;
   logic [15:0] Switches;
   logic [15:0] DebouncedSwitches;
   logic [15:0] SwitchEdge;
   logic        SampleTick;

   exp_t sbq[$];
   int   cyc;
   int   total;
   int   passed;

   switch_debouncer #(
      .SAMPLE_DIV  (SD),
      .STABLE_COUNT(SC)
   ) dut (
      .SYSCLK           (SYSCLK),
      .RST              (RST),
      .Switches         (Switches),
      .DebouncedSwitches(DebouncedSwitches),
      .SwitchEdge       (SwitchEdge),
      .SampleTick       (SampleTick)
   );

   initial SYSCLK = 1'b0;
   always #5 SYSCLK = ~SYSCLK;

   initial begin
      #500000;
      $display("FAIL watchdog: sim time exceeded, got no summary, required finish");
      $fatal(1);
   end

   // Cycle at which an input change driven in cycle drv becomes visible.
   function automatic int acceptCyc(input int drv);
      int t;
      t = drv + 2;
      while ((t % SD) != 0) t++;
      return t + SD * (SC - 1) + 1;
   endfunction

   function automatic exp_t mkExp(input int c, input logic [15:0] d,
                                  input logic [15:0] e);
      exp_t x;
      x.cyc = c;
      x.deb = d;
      x.edg = e;
      return x;
   endfunction

   task automatic step();
      @(posedge SYSCLK);
      @(negedge SYSCLK);
      cyc++;
   endtask

   task automatic applyReset(input logic [15:0] sw);
      @(negedge SYSCLK);
      Switches = sw;
      RST = 1'b0;
      @(negedge SYSCLK);
      @(negedge SYSCLK);
      RST = 1'b1;
      cyc = 1;
      sbq.delete();
   endtask

   task automatic test_reset();
      logic expTick;
      @(negedge SYSCLK);
      Switches = 16'h0000;
      RST = 1'b0;
      #1;
      total++;
      if (DebouncedSwitches !== 16'h0 || SwitchEdge !== 16'h0 ||
          SampleTick !== 1'b0)
         $display("FAIL reset_outputs: deb=%h edge=%h tick=%b required 0",
                  DebouncedSwitches, SwitchEdge, SampleTick);
      else passed++;
      @(negedge SYSCLK);
      RST = 1'b1;
      cyc = 1;
      for (int k = 0; k < 14; k++) begin
         expTick = ((cyc % SD) == 0);
         total++;
         if (SampleTick !== expTick)
            $display("FAIL reset_tick: cycle %0d tick=%b required %b",
                     cyc, SampleTick, expTick);
         else passed++;
         total++;
         if (DebouncedSwitches !== 16'h0 || SwitchEdge !== 16'h0)
            $display("FAIL reset_idle: cycle %0d deb=%h edge=%h required 0",
                     cyc, DebouncedSwitches, SwitchEdge);
         else passed++;
         step();
      end
   endtask

   task automatic test_rise();
      exp_t e;
      applyReset(16'h0000);
      Switches = 16'h0001;
      sbq.push_back(mkExp(acceptCyc(1), 16'h0001, 16'h0001));
      while (cyc < 20) begin
         step();
         if (SwitchEdge !== 16'h0) begin
            total++;
            if (sbq.size() == 0)
               $display("FAIL rise_edge: cycle %0d edge=%h required 0",
                        cyc, SwitchEdge);
            else begin
               e = sbq.pop_front();
               if (cyc !== e.cyc || SwitchEdge !== e.edg ||
                   DebouncedSwitches !== e.deb)
                  $display("FAIL rise_edge: cyc %0d edge %h deb %h required cyc %0d edge %h deb %h",
                           cyc, SwitchEdge, DebouncedSwitches, e.cyc, e.edg, e.deb);
               else passed++;
            end
         end
      end
      total++;
      if (sbq.size() != 0)
         $display("FAIL rise_missing: %0d edges pending required 0", sbq.size());
      else passed++;
   endtask

   task automatic test_glitch();
      exp_t e;
      applyReset(16'h0000);
      Switches = 16'h0020;
      while (cyc < 46) begin
         step();
         if (SwitchEdge !== 16'h0) begin
            total++;
            if (sbq.size() == 0)
               $display("FAIL glitch_edge: cycle %0d edge=%h required 0",
                        cyc, SwitchEdge);
            else begin
               e = sbq.pop_front();
               if (cyc !== e.cyc || SwitchEdge !== e.edg ||
                   DebouncedSwitches !== e.deb)
                  $display("FAIL glitch_edge: cyc %0d edge %h deb %h required cyc %0d edge %h deb %h",
                           cyc, SwitchEdge, DebouncedSwitches, e.cyc, e.edg, e.deb);
               else passed++;
            end
         end
         if (cyc == 9) Switches = 16'h0000;
         if (cyc == 29) begin
            total++;
            if (DebouncedSwitches !== 16'h0)
               $display("FAIL glitch_hold: deb=%h required 0000",
                        DebouncedSwitches);
            else passed++;
         end
         if (cyc == 30) begin
            Switches = 16'h0020;
            sbq.push_back(mkExp(acceptCyc(30), 16'h0020, 16'h0020));
         end
      end
      total++;
      if (sbq.size() != 0)
         $display("FAIL glitch_missing: %0d edges pending required 0", sbq.size());
      else passed++;
   endtask

   task automatic test_multi();
      exp_t e;
      applyReset(16'h0000);
      Switches = 16'hA5A5;
      sbq.push_back(mkExp(acceptCyc(1), 16'hA5A5, 16'hA5A5));
      while (cyc < 18) begin
         step();
         if (SwitchEdge !== 16'h0) begin
            total++;
            if (sbq.size() == 0)
               $display("FAIL multi_edge: cycle %0d edge=%h required 0",
                        cyc, SwitchEdge);
            else begin
               e = sbq.pop_front();
               if (cyc !== e.cyc || SwitchEdge !== e.edg ||
                   DebouncedSwitches !== e.deb)
                  $display("FAIL multi_edge: cyc %0d edge %h deb %h required cyc %0d edge %h deb %h",
                           cyc, SwitchEdge, DebouncedSwitches, e.cyc, e.edg, e.deb);
               else passed++;
            end
         end
      end
      total++;
      if (sbq.size() != 0 || DebouncedSwitches !== 16'hA5A5)
         $display("FAIL multi_final: pending %0d deb=%h required 0 / a5a5",
                  sbq.size(), DebouncedSwitches);
      else passed++;
   endtask

   task automatic test_reset_mid();
      exp_t e;
      applyReset(16'h0000);
      Switches = 16'h0001;
      sbq.push_back(mkExp(acceptCyc(1), 16'h0001, 16'h0001));
      while (cyc < 24) begin
         step();
         if (SwitchEdge !== 16'h0) begin
            total++;
            if (sbq.size() == 0)
               $display("FAIL rstmid_edge: cycle %0d edge=%h required 0",
                        cyc, SwitchEdge);
            else begin
               e = sbq.pop_front();
               if (cyc !== e.cyc || SwitchEdge !== e.edg ||
                   DebouncedSwitches !== e.deb)
                  $display("FAIL rstmid_edge: cyc %0d edge %h deb %h required cyc %0d edge %h deb %h",
                           cyc, SwitchEdge, DebouncedSwitches, e.cyc, e.edg, e.deb);
               else passed++;
            end
         end
         if (cyc == 13) Switches = 16'h0009;
      end
      total++;
      if (SampleTick !== 1'b1 || DebouncedSwitches !== 16'h0001)
         $display("FAIL rstmid_pre: tick=%b deb=%h required 1 / 0001",
                  SampleTick, DebouncedSwitches);
      else passed++;
      RST = 1'b0;
      #1;
      total++;
      if (DebouncedSwitches !== 16'h0 || SwitchEdge !== 16'h0 ||
          SampleTick !== 1'b0)
         $display("FAIL rstmid_clear: deb=%h edge=%h tick=%b required 0",
                  DebouncedSwitches, SwitchEdge, SampleTick);
      else passed++;
      @(negedge SYSCLK);
      @(negedge SYSCLK);
      RST = 1'b1;
      cyc = 1;
      sbq.push_back(mkExp(acceptCyc(1), 16'h0009, 16'h0009));
      while (cyc < 18) begin
         step();
         if (SwitchEdge !== 16'h0) begin
            total++;
            if (sbq.size() == 0)
               $display("FAIL rstmid_post: cycle %0d edge=%h required 0",
                        cyc, SwitchEdge);
            else begin
               e = sbq.pop_front();
               if (cyc !== e.cyc || SwitchEdge !== e.edg ||
                   DebouncedSwitches !== e.deb)
                  $display("FAIL rstmid_post: cyc %0d edge %h deb %h required cyc %0d edge %h deb %h",
                           cyc, SwitchEdge, DebouncedSwitches, e.cyc, e.edg, e.deb);
               else passed++;
            end
         end
      end
      total++;
      if (sbq.size() != 0)
         $display("FAIL rstmid_missing: %0d edges pending required 0", sbq.size());
      else passed++;
   endtask

   task automatic test_fall();
      exp_t e;
      applyReset(16'h0000);
      Switches = 16'h0002;
      sbq.push_back(mkExp(acceptCyc(1), 16'h0002, 16'h0002));
      while (cyc < 38) begin
         step();
         if (SwitchEdge !== 16'h0) begin
            total++;
            if (sbq.size() == 0)
               $display("FAIL fall_edge: cycle %0d edge=%h required 0",
                        cyc, SwitchEdge);
            else begin
               e = sbq.pop_front();
               if (cyc !== e.cyc || SwitchEdge !== e.edg ||
                   DebouncedSwitches !== e.deb)
                  $display("FAIL fall_edge: cyc %0d edge %h deb %h required cyc %0d edge %h deb %h",
                           cyc, SwitchEdge, DebouncedSwitches, e.cyc, e.edg, e.deb);
               else passed++;
            end
         end
         if (cyc == 20) begin
            Switches = 16'h0000;
            sbq.push_back(mkExp(acceptCyc(20), 16'h0000, 16'h0002));
         end
      end
      total++;
      if (sbq.size() != 0)
         $display("FAIL fall_missing: %0d edges pending required 0", sbq.size());
      else passed++;
   endtask

   task automatic test_back_to_back();
      exp_t e;
      applyReset(16'h0000);
      Switches = 16'h0004;
      sbq.push_back(mkExp(acceptCyc(1), 16'h0004, 16'h0004));
      while (cyc < 22) begin
         step();
         if (SwitchEdge !== 16'h0) begin
            total++;
            if (sbq.size() == 0)
               $display("FAIL b2b_edge: cycle %0d edge=%h required 0",
                        cyc, SwitchEdge);
            else begin
               e = sbq.pop_front();
               if (cyc !== e.cyc || SwitchEdge !== e.edg ||
                   DebouncedSwitches !== e.deb)
                  $display("FAIL b2b_edge: cyc %0d edge %h deb %h required cyc %0d edge %h deb %h",
                           cyc, SwitchEdge, DebouncedSwitches, e.cyc, e.edg, e.deb);
               else passed++;
            end
         end
         if (cyc == 5) begin
            Switches = 16'h0084;
            sbq.push_back(mkExp(acceptCyc(5), 16'h0084, 16'h0080));
         end
      end
      total++;
      if (sbq.size() != 0)
         $display("FAIL b2b_missing: %0d edges pending required 0", sbq.size());
      else passed++;
   endtask

   initial begin
      total    = 0;
      passed   = 0;
      cyc      = 0;
      RST      = 1'b0;
      Switches = 16'h0000;
      test_reset();
      test_rise();
      test_glitch();
      test_multi();
      test_reset_mid();
      test_fall();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/switch_debouncer.md
SWITCH_DEBOUNCER -- requirements
Module: switch_debouncer

Interface
REQ-001 The block SHALL have parameter SAMPLE_DIV, default 100000, clock cycles per sample tick (range 2..2^20).
REQ-002 The block SHALL have parameter STABLE_COUNT, default 4, consecutive differing samples required to accept a change (range 2..15).
REQ-003 The block SHALL have port SYSCLK, input, 1, the single system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port RST, input, 1, reset, asynchronous and active-low.
REQ-005 The block SHALL have port Switches, input, 16, raw asynchronous slide-switch levels.
REQ-006 The block SHALL have port DebouncedSwitches, output, 16, registered debounced switch levels.
REQ-007 The block SHALL have port SwitchEdge, output, 16, one-cycle pulse per bit when that DebouncedSwitches bit changes.
REQ-008 The block SHALL have port SampleTick, output, 1, one-cycle pulse marking each sample instant.

Function
REQ-009 Each Switches bit SHALL pass through a two-flop synchronizer (sync1, sync2) before any other use.
REQ-010 A prescaler SHALL count 0..SAMPLE_DIV-1 and wrap to 0; SampleTick SHALL be 1 exactly in cycles where prescaler == SAMPLE_DIV-1.
REQ-011 The prescaler width SHALL be ceil(log2(SAMPLE_DIV)); no other wrap value is permitted.
REQ-012 Each bit SHALL own an independent stable counter of width ceil(log2(STABLE_COUNT)), holding its value in cycles without SampleTick.
REQ-013 Per-bit states: IDLE (counter == 0, sync2 == debounced) and PENDING (counter > 0); no shared state between bits.
REQ-014 On SampleTick with sync2 != DebouncedSwitches[i] and counter < STABLE_COUNT-1: counter increments (IDLE -> PENDING or PENDING -> PENDING).
REQ-015 On SampleTick with sync2 != DebouncedSwitches[i] and counter == STABLE_COUNT-1: DebouncedSwitches[i] <= sync2, counter <= 0, SwitchEdge[i] <= 1 (PENDING -> IDLE).
REQ-016 On SampleTick with sync2 == DebouncedSwitches[i]: counter <= 0 (glitch rejected, PENDING -> IDLE).
REQ-017 SwitchEdge[i] SHALL be 1 for exactly one cycle, the same cycle DebouncedSwitches[i] first shows the new value; 0 otherwise.
REQ-018 Acceptance latency SHALL be exactly STABLE_COUNT SampleTicks after sync2 first differs at a tick; raw-to-sync2 latency is 2 cycles.
REQ-019 Pulses of any width that do not persist across STABLE_COUNT consecutive ticks SHALL never change DebouncedSwitches.
REQ-020 Multiple bits accepting on the same tick SHALL all update and pulse SwitchEdge in the same cycle.
REQ-021 Samples are only the sync2 value at SampleTick cycles; activity between ticks is ignored.

Reset
REQ-022 RST low SHALL immediately clear prescaler, synchronizers, all stable counters, DebouncedSwitches = 16'h0000, SwitchEdge = 16'h0000, SampleTick = 0.
REQ-023 Reset asserted mid-PENDING SHALL discard the pending count; after release, counting restarts from 0.
REQ-024 After RST deasserts, the first SampleTick SHALL occur in cycle SAMPLE_DIV (prescaler starts at 0).
REQ-025 A switch held high through reset SHALL appear on DebouncedSwitches only after STABLE_COUNT ticks post-release, with a SwitchEdge pulse.

Verification (SAMPLE_DIV=4, STABLE_COUNT=3)
REQ-026 Reset release, Switches=16'h0000 -> SampleTick pulses at cycles 4, 8, 12; DebouncedSwitches stays 16'h0000, SwitchEdge stays 0.
REQ-027 Switches[0] 0->1 and held -> DebouncedSwitches=16'h0001 at the 3rd tick after sync2 goes high; SwitchEdge=16'h0001 for one cycle only.
REQ-028 Switches[5] high for 2 ticks then low -> DebouncedSwitches[5] stays 0, counter returns to 0, no SwitchEdge.
REQ-029 Switches 16'h0000 -> 16'hA5A5 in one cycle -> all eight bits update on the same tick; SwitchEdge=16'hA5A5 for one cycle.
REQ-030 Switches[3] held high, RST pulsed low after 2 ticks -> outputs 0 immediately; after release DebouncedSwitches[3]=1 at 3rd tick post-release.
REQ-031 Debounced bit 1 at 1, Switches[1] falls and held -> DebouncedSwitches[1]=0 after 3 ticks; SwitchEdge[1] pulses once.
